// File: rtl/ws2812_scroll_frame.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_scroll_frame
// Purpose  : Frame source for the WS2812 matrix driver. It holds a
//            column-addressed pattern memory that is wider than the LED array
//            and slides an N-column window across it at a programmable rate.
//            Each window is built column by column into a shadow buffer and
//            then committed to arry_data in a single cycle, so the driver
//            never sees a partially built frame.
// Ports    : clk        system clock
//            rst_n      asynchronous active-low reset
//            scroll_en  1 = window advances every SCROLL_TICKS clocks
//            dir        0 = offset +1 per step, 1 = offset -1 per step
//            wr_en      single-cycle column write strobe
//            wr_addr    pattern column to write (ignored if >= PATTERN_LEN)
//            wr_col     column bits, bit r = row r
//            arry_data  committed frame, arry_data[row][col]
//            frame_tick one-cycle pulse when arry_data changes
//            offset     current window start column
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_scroll_frame #(
  parameter int WS2812_M     = 8,
  parameter int WS2812_N     = 8,
  parameter int PATTERN_LEN  = 32,
  parameter int SCROLL_TICKS = 10_000_000
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                scroll_en,
  input  logic                                dir,
  input  logic                                wr_en,
  input  logic [$clog2(PATTERN_LEN)-1:0]      wr_addr,
  input  logic [WS2812_M-1:0]                 wr_col,
  output logic [WS2812_M-1:0][WS2812_N-1:0]   arry_data,
  output logic                                frame_tick,
  output logic [$clog2(PATTERN_LEN)-1:0]      offset
);

  localparam int c_AW = $clog2(PATTERN_LEN);
  localparam int c_CW = $clog2(WS2812_N);
  // +1 keeps the timer at least one bit wide when SCROLL_TICKS is 1.
  localparam int c_TW = $clog2(SCROLL_TICKS + 1);

  localparam logic [c_AW:0]   c_PLEN      = (c_AW + 1)'(PATTERN_LEN);
  localparam logic [c_AW-1:0] c_OFF_MAX   = c_AW'(PATTERN_LEN - 1);
  localparam logic [c_CW-1:0] c_COL_LAST  = c_CW'(WS2812_N - 1);
  localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(SCROLL_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUILD  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [WS2812_M-1:0]             r_pattern [PATTERN_LEN];
  logic [WS2812_M-1:0]             r_shadow  [WS2812_N];
  logic [WS2812_M-1:0][WS2812_N-1:0] r_arry;
  logic                            r_frame_tick;
  logic [c_TW-1:0]                 r_timer;
  logic [c_AW-1:0]                 r_offset;
  logic [c_AW-1:0]                 r_build_off;
  logic [c_CW-1:0]                 r_col;
  logic                            r_pending;

  logic                            w_wr_ok;
  logic                            w_step;
  logic                            w_req;
  logic                            w_take;
  logic                            w_build;
  logic                            w_commit;
  logic [c_AW:0]                   w_sum;
  logic [c_AW-1:0]                 w_rd_addr;

  assign w_wr_ok = wr_en & ({1'b0, wr_addr} < c_PLEN);
  assign w_step  = scroll_en & (r_timer == c_TICK_LAST);
  // A write and a step on the same edge collapse into one request.
  assign w_req   = w_wr_ok | w_step;

  // build_off + c is always below 2*PATTERN_LEN, so one conditional
  // subtract is a complete modulo.
  assign w_sum     = {1'b0, r_build_off} + (c_AW + 1)'(r_col);
  assign w_rd_addr = (w_sum >= c_PLEN) ? c_AW'(w_sum - c_PLEN) : c_AW'(w_sum);

  // --------------------------------------------------------------------------
  // Pattern memory
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PATTERN_LEN; i++) begin
        r_pattern[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_pattern[wr_addr] <= wr_col;
    end
  end

  // --------------------------------------------------------------------------
  // Step timer and window offset
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer  <= '0;
      r_offset <= '0;
    end else begin
      if (!scroll_en || w_step) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + c_TW'(1);
      end

      if (w_step) begin
        if (dir) begin
          r_offset <= (r_offset == '0) ? c_OFF_MAX : r_offset - c_AW'(1);
        end else begin
          r_offset <= (r_offset == c_OFF_MAX) ? '0 : r_offset + c_AW'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame builder FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_build     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending) begin
          w_take      = 1'b1;
          w_state_nxt = S_BUILD;
        end
      end
      S_BUILD: begin
        w_build = 1'b1;
        if (r_col == c_COL_LAST) begin
          w_state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request flag, shadow build and commit
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending    <= 1'b0;
      r_build_off  <= '0;
      r_col        <= '0;
      r_frame_tick <= 1'b0;
      r_arry       <= '0;
      for (int c = 0; c < WS2812_N; c++) begin
        r_shadow[c] <= '0;
      end
    end else begin
      // A new request on the same edge IDLE consumes the flag re-arms it,
      // so that request gets its own follow-up frame.
      r_pending    <= w_req | (r_pending & ~w_take);
      r_frame_tick <= w_commit;

      if (w_take) begin
        r_build_off <= r_offset;
        r_col       <= '0;
      end else if (w_build) begin
        r_col <= r_col + c_CW'(1);
      end

      if (w_build) begin
        r_shadow[r_col] <= r_pattern[w_rd_addr];
      end

      if (w_commit) begin
        for (int r = 0; r < WS2812_M; r++) begin
          for (int c = 0; c < WS2812_N; c++) begin
            r_arry[r][c] <= r_shadow[c][r];
          end
        end
      end
    end
  end

  assign arry_data  = r_arry;
  assign frame_tick = r_frame_tick;
  assign offset     = r_offset;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_scroll_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws2812_scroll_frame
// Purpose  : Directed self-checking bench for ws2812_scroll_frame with
//            M=N=8, PATTERN_LEN=10, SCROLL_TICKS=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812_scroll_frame;

  localparam int c_M  = 8;
  localparam int c_N  = 8;
  localparam int c_PL = 10;
  localparam int c_ST = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    scroll_en;
  logic                    dir;
  logic                    wr_en;
  logic [3:0]              wr_addr;
  logic [7:0]              wr_col;
  logic [c_M-1:0][c_N-1:0] arry_data;
  logic                    frame_tick;
  logic [3:0]              offset;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tick_cnt = 0;

  // Hand-chosen distinct column values: pat[i] = 0x11 * (i+1).
  logic [7:0] pat [c_PL] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                             8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};

  ws2812_scroll_frame #(
    .WS2812_M     (c_M),
    .WS2812_N     (c_N),
    .PATTERN_LEN  (c_PL),
    .SCROLL_TICKS (c_ST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scroll_en  (scroll_en),
    .dir        (dir),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_col     (wr_col),
    .arry_data  (arry_data),
    .frame_tick (frame_tick),
    .offset     (offset)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_tick === 1'b1) tick_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_frame(input int off);
    logic [63:0] f;
    f = '0;
    for (int c = 0; c < c_N; c++) begin
      for (int r = 0; r < c_M; r++) begin
        f[r*c_N + c] = pat[(off + c) % c_PL][r];
      end
    end
    return f;
  endfunction

  function automatic logic [7:0] col_of(input logic [63:0] f, input int c);
    logic [7:0] v;
    for (int r = 0; r < c_M; r++) v[r] = f[r*c_N + c];
    return v;
  endfunction

  // Called at a negedge; the write is sampled on the following posedge.
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_col  = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_step(output int n);
    logic [3:0] prev;
    prev = offset;
    n = 0;
    while (offset == prev && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_frame(output logic [63:0] f, output int at);
    int k;
    k  = 0;
    f  = '0;
    at = -1;
    do begin
      @(negedge clk);
      k++;
    end while (frame_tick !== 1'b1 && k < 40);
    if (frame_tick === 1'b1) begin
      f  = arry_data;
      at = cyc;
    end else begin
      check("frame_timeout", 64'd0, 64'd1);
    end
  endtask

  initial begin
    logic [63:0] f1, f2;
    int          at1, at2, n, t0;

    rst_n = 1'b0; scroll_en = 1'b0; dir = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_col = '0;
    repeat (3) @(negedge clk);
    check("rst_arry",   arry_data,  64'd0);
    check("rst_offset", offset,     64'd0);
    check("rst_tick",   frame_tick, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two consecutive column writes with scrolling off.
    t0 = tick_cnt;
    wr(4'd0, 8'h01);
    wr(4'd1, 8'h03);
    repeat (30) @(negedge clk);
    check("load_ticks_1or2", ((tick_cnt - t0) >= 1) && ((tick_cnt - t0) <= 2), 64'd1);
    check("load_frame",  arry_data, 64'h0000_0000_0000_0203);
    check("load_offset", offset,    64'd0);

    // Out-of-range addresses are dropped and raise no request.
    t0 = tick_cnt;
    wr(4'd10, 8'hFF);
    wr(4'd15, 8'hFF);
    repeat (20) @(negedge clk);
    check("badaddr_ticks", tick_cnt - t0, 64'd0);
    check("badaddr_frame", arry_data, 64'h0000_0000_0000_0203);

    // Full pattern load.
    for (int i = 0; i < c_PL; i++) wr(4'(i), pat[i]);
    repeat (30) @(negedge clk);
    check("full_frame", arry_data, exp_frame(0));

    // Write to col3 lands while BUILD is reading c=5.
    t0 = tick_cnt;
    wr(4'd9, pat[9]);
    repeat (6) @(negedge clk);
    wr(4'd3, 8'h5A);
    wait_frame(f1, at1);
    check("coll_first_col3", col_of(f1, 3), 8'h44);
    check("coll_first_frame", f1, exp_frame(0));
    pat[3] = 8'h5A;
    wait_frame(f2, at2);
    check("coll_second_col3", col_of(f2, 3), 8'h5A);
    check("coll_second_frame", f2, exp_frame(0));
    check("coll_spacing", at2 - at1, 64'd10);
    repeat (30) @(negedge clk);
    check("coll_tick_count", tick_cnt - t0, 64'd2);

    // Scroll left: offset 1..9, wrap to 0, then on to 5.
    dir = 1'b0;
    scroll_en = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      wait_step(n);
      check($sformatf("left_off_%0d", i), offset, 64'(i % c_PL));
      check($sformatf("left_gap_%0d", i), n, 64'd4);
    end
    scroll_en = 1'b0;
    repeat (30) @(negedge clk);
    check("left_hold_off", offset, 64'd5);
    check("left_col7", col_of(arry_data, 7), 8'h33);
    check("left_frame", arry_data, exp_frame(5));

    // Reset in the middle of a BUILD.
    wr(4'd0, pat[0]);
    repeat (3) @(negedge clk);
    check("pre_rst_nonzero", arry_data != '0, 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_arry",   arry_data,  64'd0);
    check("midrst_offset", offset,     64'd0);
    check("midrst_tick",   frame_tick, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t0 = tick_cnt;
    repeat (20) @(negedge clk);
    check("postrst_ticks", tick_cnt - t0, 64'd0);
    check("postrst_arry",  arry_data,     64'd0);

    // Reload and scroll right once from offset 0.
    for (int i = 0; i < c_PL; i++) wr(4'(i), pat[i]);
    repeat (30) @(negedge clk);
    check("reload_frame", arry_data, exp_frame(0));
    dir = 1'b1;
    scroll_en = 1'b1;
    wait_step(n);
    scroll_en = 1'b0;
    check("right_off", offset, 64'd9);
    check("right_gap", n, 64'd4);
    repeat (30) @(negedge clk);
    check("right_col0", col_of(arry_data, 0), 8'hAA);
    check("right_col7", col_of(arry_data, 7), 8'h77);
    check("right_frame", arry_data, exp_frame(9));

    // scroll_en dropped mid-count restarts the timer.
    dir = 1'b0;
    scroll_en = 1'b1;
    repeat (2) @(negedge clk);
    scroll_en = 1'b0;
    repeat (3) @(negedge clk);
    check("toggle_no_step", offset, 64'd9);
    scroll_en = 1'b1;
    wait_step(n);
    scroll_en = 1'b0;
    check("toggle_gap", n, 64'd4);
    check("toggle_wrap_off", offset, 64'd0);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ws2812_scroll_frame.md
# ws2812_scroll_frame

Frame source for the WS2812 matrix driver. It holds a column-addressed pattern memory wider than the physical M×N LED array and slides an N-column window across it at a programmable rate. It presents the window as the driver's `arry_data[M-1:0][N-1:0]` bit matrix and updates it atomically, one committed frame at a time. It sits directly upstream of the matrix driver; its `arry_data` output feeds the driver's `arry_data` input unchanged.

## Interface
- `WS2812_M`, 8, rows; must equal the driver's row count.
- `WS2812_N`, 8, columns; must equal the driver's column count. Must be ≥2.
- `PATTERN_LEN`, 32, pattern memory depth in columns. Must be ≥ `WS2812_N`. Need not be a power of two.
- `SCROLL_TICKS`, 10_000_000, clocks per scroll step (0.2 s at 50 MHz). Must be ≥1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `scroll_en`  in  1  1 = window advances every `SCROLL_TICKS` clocks.
- `dir`  in  1  0 = offset +1 per step (content moves left); 1 = offset −1 per step.
- `wr_en`  in  1  single-cycle column write strobe.
- `wr_addr`  in  $clog2(PATTERN_LEN)  column index to write.
- `wr_col`  in  WS2812_M  column bits; bit r = row r.
- `arry_data`  out  [WS2812_M-1:0][WS2812_N-1:0]  committed frame.
- `frame_tick`  out  1  one-cycle pulse when `arry_data` changes.
- `offset`  out  $clog2(PATTERN_LEN)  current window start column.

## Operation
- Pattern memory: `PATTERN_LEN` × `WS2812_M` bits. It is cleared by reset.
- Writes:
  - With `wr_en`=1 and `wr_addr` < `PATTERN_LEN`, `pattern[wr_addr]` ← `wr_col` at the sampling edge, and a rebuild request is raised.
  - If `wr_addr` ≥ `PATTERN_LEN`, the write is ignored and no request is raised.
- Step timer:
  - Counts only while `scroll_en`=1. It is held at 0 while `scroll_en`=0.
  - On reaching `SCROLL_TICKS`−1 it wraps to 0 and performs a step.
  - A step updates `offset` ← `(offset+1) mod PATTERN_LEN` when `dir`=0, or `(offset−1) mod PATTERN_LEN` when `dir`=1. Wrap cases: 0−1 → `PATTERN_LEN`−1; `PATTERN_LEN`−1 +1 → 0.
  - A step raises a rebuild request.
- Window mapping: `arry_data[r][c] = pattern[(build_off + c) mod PATTERN_LEN][r]`, for r < M and c < N.
  - The sum is < 2·`PATTERN_LEN`, so the modulo is a single compare-and-subtract. No divider.
- Rebuild requests set a sticky `pending` flag. Simultaneous write and step in the same cycle produce one request.
- FSM:
  - IDLE: if `pending`, then `build_off` ← `offset`, `pending` ← 0, column counter c ← 0, go to BUILD.
  - BUILD: each cycle, read column `(build_off+c) mod PATTERN_LEN` into shadow column c and increment c. After c = N−1, go to COMMIT. Lasts exactly N cycles.
  - COMMIT: `arry_data` ← shadow, `frame_tick` ← 1, go to IDLE.
- Requests during BUILD or COMMIT are absorbed into `pending`. At most one additional rebuild follows, and it uses the newest `offset`. `build_off` is frozen for the frame in progress.
- A write landing during BUILD is visible to the current frame only if its column has not yet been read. The follow-up rebuild always reflects it.
- `arry_data` never shows a partially built frame.

## Timing
- Reset values, applied asynchronously on `rst_n`=0:
  - `arry_data` = 0, `frame_tick` = 0, `offset` = 0.
  - Pattern memory = 0, timer = 0, `pending` = 0, state = IDLE.
- Reset mid-BUILD aborts the frame; no `frame_tick` is emitted.
- Latency, with the request registered at edge k:
  - IDLE sees `pending` at edge k+1.
  - BUILD occupies edges k+2 … k+N+1.
  - COMMIT is at edge k+N+2.
  - New `arry_data` and `frame_tick`=1 are visible after edge k+N+2, with `frame_tick` high for exactly one cycle.
- Minimum spacing between `frame_tick` pulses: N+2 cycles.
- `offset` updates on the step edge itself, ahead of `arry_data`.

## Test plan
- Reset: assert `rst_n`=0 mid-BUILD with `arry_data` non-zero → `arry_data`, `offset` and `frame_tick` all read 0 immediately. No tick follows the release of reset.
- Load with N=8, `PATTERN_LEN`=10, `scroll_en`=0: write col0=8'h01, then col1=8'h03 on consecutive cycles → exactly one or two `frame_tick` pulses. Final frame has `arry_data[0][0]`=1, `[0][1]`=1, `[1][1]`=1, all other bits 0. `offset` stays 0.
- Scroll left with `SCROLL_TICKS`=4, `dir`=0, distinct pattern columns → `offset` steps every 4 cycles 0,1,…,9,0. After each commit, column c of `arry_data` equals `pattern[(offset+c) mod 10]`, e.g. offset 5 gives column 7 = `pattern[2]`.
- Scroll right with `dir`=1 from `offset` 0 → `offset`=9, column 0 = `pattern[9]`, column 7 = `pattern[6]`.
- Collision: write col3 while BUILD is at c=5 with offset 0 → first tick shows the old col3, second tick (N+2 cycles later) shows the new col3. No third tick.
- `scroll_en` toggled low for 3 cycles mid-count → timer restarts from 0. Next step occurs 4 cycles after `scroll_en` returns high.
